ov_cam_init_seq: RTL and testbench
==================================

Name: ov_cam_init_seq

Overview:
Camera register initialisation sequencer that sits directly upstream of the SCCB master. It walks a table of (sub-address, data) pairs held in an external synchronous ROM and issues one 3-phase SCCB write per entry over the master's tr_start/busy handshake. It also supports inline delay entries and an end-of-table marker, and reports completion or timeout to the system controller.

Parameters:
DEV_ADDR, 8'h42, SCCB device write address driven on addr (bit0 always 0)
TBL_DEPTH, 64, maximum table entries; the index wraps to an error beyond this
IDX_W, 6, ROM index width, equal to clog2(TBL_DEPTH)
PWR_WAIT, 1024, clk cycles to wait after start before the first transaction
DLY_UNIT, 1000, clk cycles per delay-entry count
BUSY_TMO, 64, max clk cycles to wait for busy to rise after tr_start

Ports:
clk  in  1  system clock, shared with the SCCB master
reset  in  1  synchronous, active-low
start  in  1  one-cycle pulse that begins the init sequence; ignored unless in IDLE, DONE or ERROR
rom_addr  out  IDX_W  table index presented to the ROM
rom_data  in  16  ROM word: [15:8] sub-address, [7:0] data; valid 1 cycle after rom_addr
addr  out  8  SCCB device address, constant DEV_ADDR
subaddr  out  8  register sub-address for the current write
w_data  out  8  register data for the current write
tr_start  out  1  transaction request to the SCCB master
busy  in  1  SCCB master busy
init_done  out  1  high when the table completed successfully; held until the next start
init_err  out  1  high on timeout or table overrun; held until the next start
wr_count  out  IDX_W+1  number of SCCB writes completed in the current run

Behaviour:
- Reset values, applied when reset=0 at a clk edge, overriding everything:
  - state=IDLE
  - rom_addr=0, subaddr=0, w_data=0, tr_start=0
  - init_done=0, init_err=0, wr_count=0
  - internal counters=0
  - addr is DEV_ADDR at all times
- States: IDLE, PWR, FETCH, DECODE, REQ, XFER, DLY, DONE, ERR.
- IDLE / DONE / ERR:
  - On start=1: clear init_done, init_err, wr_count and rom_addr; load the wait counter with PWR_WAIT-1; go to PWR.
  - DONE and ERR hold their flags until a start arrives.
- PWR: decrement the counter; when it reaches 0, go to FETCH.
- FETCH: one cycle for ROM latency; rom_addr is stable; go to DECODE.
- DECODE: sample rom_data.
  - rom_data==16'hFFFF: end of table; set init_done=1; go to DONE.
  - rom_data[15:8]==8'hFF with data n (n != 8'hFF): delay entry.
    - n=0 is a zero-length delay.
    - Otherwise load the counter with n*DLY_UNIT-1 (counter width at least 8+clog2(DLY_UNIT) bits) and go to DLY.
  - Otherwise: latch subaddr=rom_data[15:8] and w_data=rom_data[7:0]; set tr_start=1; clear the timeout counter; go to REQ.
- REQ:
  - Hold tr_start=1 until busy=1 is sampled, then drop tr_start and go to XFER.
  - If BUSY_TMO cycles elapse without busy=1: tr_start=0, init_err=1, go to ERR.
- XFER: wait for busy=0. Then increment wr_count and rom_addr, and go to FETCH.
  - subaddr and w_data must stay stable from DECODE until busy falls.
- DLY: decrement the counter; at 0, increment rom_addr and go to FETCH.
- Table overrun: when rom_addr is TBL_DEPTH-1 and that entry is consumed without reaching end-of-table, set init_err=1 and go to ERR. rom_addr never wraps to 0 silently.
- start pulses in any state other than IDLE/DONE/ERR are ignored; there is no restart mid-sequence.
- Reset mid-transaction: the sequencer returns to IDLE and tr_start drops in the same cycle. The SCCB master, on the same reset, also returns to idle.
- init_done and init_err are never both 1.
- Latency: a write entry takes 2 cycles (FETCH+DECODE) plus the handshake. With an immediate-responding master, tr_start is high for exactly 2 cycles (DECODE sets it, then busy is seen the next REQ cycle).

Test Plan:
1. Reset, start, table {0x1280, 0x1101, 0xFFFF}, PWR_WAIT=8, master model raises busy 1 cycle after tr_start for 30 cycles -> two writes seen as (0x12,0x80) then (0x11,0x01); addr=0x42 throughout; wr_count=2; init_done=1 after the third DECODE; init_err=0.
2. Table {0xFF03, 0x3A04, 0xFFFF}, DLY_UNIT=10 -> first tr_start occurs no earlier than 30 cycles after DECODE of entry 0; one write (0x3A,0x04) follows.
3. Master never asserts busy, BUSY_TMO=64 -> tr_start high for exactly 64 cycles, then low; init_err=1; wr_count=0; init_done=0.
4. TBL_DEPTH=4 with no 0xFFFF entry -> exactly 4 writes, then init_err=1; rom_addr never returns to 0 during the run.
5. Reset driven low while in XFER -> next cycle: state IDLE, tr_start=0, wr_count=0; a new start replays the table from index 0.
6. start pulsed again during PWR and XFER -> no effect on the sequence. After DONE, a start clears init_done within 1 cycle and reruns identically.

Source files
------------

// File: rtl/ov_cam_init_seq.sv
// rtl/ov_cam_init_seq.sv - camera register init sequencer driving an SCCB master from a ROM table
module ov_cam_init_seq #(
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         TBL_DEPTH = 64,
  parameter int         IDX_W     = 6,
  parameter int         PWR_WAIT  = 1024,
  parameter int         DLY_UNIT  = 1000,
  parameter int         BUSY_TMO  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [15:0]      rom_data,
  output logic [7:0]       addr,
  output logic [7:0]       subaddr,
  output logic [7:0]       w_data,
  output logic             tr_start,
  input  logic             busy,
  output logic             init_done,
  output logic             init_err,
  output logic [IDX_W:0]   wr_count
);

  // one counter serves both the power-up wait and delay entries, so size it for the larger
  localparam int DLY_W = 8 + $clog2(DLY_UNIT);
  localparam int PWR_W = $clog2(PWR_WAIT + 1);
  localparam int CNT_W = (DLY_W > PWR_W) ? DLY_W : PWR_W;
  localparam int TMO_W = $clog2(BUSY_TMO + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_DEPTH - 1);
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] DLY_MUL  = CNT_W'(DLY_UNIT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_DECODE, S_REQ, S_XFER, S_DLY, S_DONE, S_ERR
  } state_t;

  state_t           r_state, w_state_nx;
  logic [IDX_W-1:0] r_rom_addr, w_rom_addr_nx;
  logic [7:0]       r_subaddr, w_subaddr_nx;
  logic [7:0]       r_w_data, w_w_data_nx;
  logic             r_tr_start, w_tr_start_nx;
  logic             r_done, w_done_nx;
  logic             r_err, w_err_nx;
  logic [IDX_W:0]   r_wr_count, w_wr_count_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [TMO_W-1:0] r_tmo, w_tmo_nx;
  logic             w_last;
  logic [CNT_W-1:0] w_dly_load;

  assign w_last     = (r_rom_addr == LAST_IDX);
  assign w_dly_load = CNT_W'(rom_data[7:0]) * DLY_MUL - CNT_W'(1);

  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rom_addr <= '0;
      r_subaddr  <= '0;
      r_w_data   <= '0;
      r_tr_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_rom_addr <= w_rom_addr_nx;
      r_subaddr  <= w_subaddr_nx;
      r_w_data   <= w_w_data_nx;
      r_tr_start <= w_tr_start_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
      r_wr_count <= w_wr_count_nx;
      r_cnt      <= w_cnt_nx;
      r_tmo      <= w_tmo_nx;
    end
  end

  // next-state and next-register logic; the last table slot never wraps, it errors instead
  always_comb begin
    w_state_nx    = r_state;
    w_rom_addr_nx = r_rom_addr;
    w_subaddr_nx  = r_subaddr;
    w_w_data_nx   = r_w_data;
    w_tr_start_nx = r_tr_start;
    w_done_nx     = r_done;
    w_err_nx      = r_err;
    w_wr_count_nx = r_wr_count;
    w_cnt_nx      = r_cnt;
    w_tmo_nx      = r_tmo;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_done_nx     = 1'b0;
          w_err_nx      = 1'b0;
          w_wr_count_nx = '0;
          w_rom_addr_nx = '0;
          w_cnt_nx      = PWR_LOAD;
          w_state_nx    = S_PWR;
        end
      end
      S_PWR: begin
        if (r_cnt == '0) w_state_nx = S_FETCH;
        else             w_cnt_nx   = r_cnt - CNT_W'(1);
      end
      S_FETCH: w_state_nx = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_DONE;
        end else if (rom_data[15:8] == 8'hFF) begin
          if (rom_data[7:0] != 8'h00) begin
            w_cnt_nx   = w_dly_load;
            w_state_nx = S_DLY;
          end else if (w_last) begin
            w_err_nx   = 1'b1;
            w_state_nx = S_ERR;
          end else begin
            w_rom_addr_nx = r_rom_addr + IDX_W'(1);
            w_state_nx    = S_FETCH;
          end
        end else begin
          w_subaddr_nx  = rom_data[15:8];
          w_w_data_nx   = rom_data[7:0];
          w_tr_start_nx = 1'b1;
          w_tmo_nx      = '0;
          w_state_nx    = S_REQ;
        end
      end
      S_REQ: begin
        if (busy) begin
          w_tr_start_nx = 1'b0;
          w_state_nx    = S_XFER;
        end else if (r_tmo == TMO_LAST) begin
          w_tr_start_nx = 1'b0;
          w_err_nx      = 1'b1;
          w_state_nx    = S_ERR;
        end else begin
          w_tmo_nx = r_tmo + TMO_W'(1);
        end
      end
      S_XFER: begin
        if (!busy) begin
          w_wr_count_nx = r_wr_count + (IDX_W+1)'(1);
          if (w_last) begin
            w_err_nx   = 1'b1;
            w_state_nx = S_ERR;
          end else begin
            w_rom_addr_nx = r_rom_addr + IDX_W'(1);
            w_state_nx    = S_FETCH;
          end
        end
      end
      S_DLY: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end else if (w_last) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_ERR;
        end else begin
          w_rom_addr_nx = r_rom_addr + IDX_W'(1);
          w_state_nx    = S_FETCH;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign addr      = {DEV_ADDR[7:1], 1'b0};
  assign rom_addr  = r_rom_addr;
  assign subaddr   = r_subaddr;
  assign w_data    = r_w_data;
  assign tr_start  = r_tr_start;
  assign init_done = r_done;
  assign init_err  = r_err;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_ov_cam_init_seq.sv
// tb/tb_ov_cam_init_seq.sv - testbench for ov_cam_init_seq
module tb_ov_cam_init_seq;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int PW    = 8;
  localparam int DU    = 10;
  localparam int TMO   = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy = 1'b0;
  logic [IW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0000;
  logic [7:0]    addr, subaddr, w_data;
  logic          tr_start, init_done, init_err;
  logic [IW:0]   wr_count;

  always #5 clk = ~clk;

  ov_cam_init_seq #(
    .DEV_ADDR(8'h42), .TBL_DEPTH(DEPTH), .IDX_W(IW),
    .PWR_WAIT(PW), .DLY_UNIT(DU), .BUSY_TMO(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .addr(addr), .subaddr(subaddr), .w_data(w_data),
    .tr_start(tr_start), .busy(busy),
    .init_done(init_done), .init_err(init_err), .wr_count(wr_count)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // synchronous table ROM
  logic [15:0] rom [DEPTH];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB master: busy rises one cycle after tr_start, stays high busy_len cycles
  bit master_en = 1'b1;
  int busy_len = 30;
  int mcnt = 0;
  always @(posedge clk) begin
    if (!reset) begin
      busy <= 1'b0;
      mcnt <= 0;
    end else if (busy) begin
      if (mcnt <= 1) busy <= 1'b0;
      else           mcnt <= mcnt - 1;
    end else if (master_en && tr_start) begin
      busy <= 1'b1;
      mcnt <= busy_len;
    end
  end

  // transaction-level model: expected writes in order, and cycles from start to first request
  logic [15:0] expq[$];
  int nseen = 0;
  int exp_ts_len = 2;

  function automatic void model(output int lat, output int nw, output bit done);
    bit seen_w = 1'b0;
    expq.delete();
    nseen = 0;
    lat = PW + 2;
    nw = 0;
    done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == 16'hFFFF) begin
        done = 1'b1;
        break;
      end else if (rom[i][15:8] == 8'hFF) begin
        if (!seen_w) lat += int'(rom[i][7:0]) * DU + 2;
      end else begin
        expq.push_back(rom[i]);
        nw++;
        seen_w = 1'b1;
      end
    end
  endfunction

  // compare process
  logic          st_q = 1'b0, rs_q = 1'b0;
  logic          prev_ts = 1'b0;
  logic [IW-1:0] prev_ra = '0;
  logic [15:0]   cur = 16'h0;
  bit            in_txn = 1'b0;
  int            ts_len = 0;

  always @(posedge clk) begin
    st_q <= start;
    rs_q <= reset;
  end

  always @(negedge clk) begin
    if (!rs_q) begin
      prev_ts = 1'b0;
      in_txn  = 1'b0;
      ts_len  = 0;
      prev_ra = rom_addr;
    end else begin
      chk("addr", addr, 8'h42);
      chk("flags_excl", init_done & init_err, 0);
      if (!st_q) chk("rom_addr_mono", rom_addr >= prev_ra, 1);
      prev_ra = rom_addr;
      if (tr_start && !prev_ts) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          cur = expq.pop_front();
          chk("subaddr", subaddr, cur[15:8]);
          chk("w_data", w_data, cur[7:0]);
          chk("wr_count_at_req", wr_count, nseen);
          nseen++;
          in_txn = 1'b1;
          ts_len = 0;
        end
      end
      if (in_txn) begin
        if (tr_start) ts_len++;
        if (tr_start || busy) begin
          chk("subaddr_stable", subaddr, cur[15:8]);
          chk("w_data_stable", w_data, cur[7:0]);
        end
        if (!tr_start && prev_ts) chk("tr_start_len", ts_len, exp_ts_len);
        if (!tr_start && !busy) in_txn = 1'b0;
      end
      prev_ts = tr_start;
    end
  end

  task automatic set_tbl(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run(input int lit_lat, input bit poke, input bit exp_done, input int exp_wc);
    int lat, nw, cyc;
    bit mdone;
    model(lat, nw, mdone);
    pulse_start();
    chk("clr_done", init_done, 0);
    chk("clr_err", init_err, 0);
    chk("clr_wr_count", wr_count, 0);
    chk("clr_rom_addr", rom_addr, 0);
    cyc = 0;
    while (!tr_start && !init_done && !init_err && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 3);
    end
    start = 1'b0;
    chk("first_req_seen", tr_start, 1);
    chk("first_req_lat_model", cyc, lat);
    chk("first_req_lat", cyc, lit_lat);
    if (poke && master_en) begin
      cyc = 0;
      while (!busy && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("busy_seen", busy, 1);
      @(negedge clk);
      pulse_start();
    end
    cyc = 0;
    while (!init_done && !init_err && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("init_done", init_done, exp_done);
    chk("init_err", init_err, !exp_done);
    chk("wr_count", wr_count, exp_wc);
    if (master_en) begin
      chk("done_vs_model", init_done, mdone);
      chk("wr_count_vs_model", wr_count, nw);
      chk("writes_left", expq.size(), 0);
    end
    repeat (3) @(negedge clk);
    chk("done_hold", init_done, exp_done);
    chk("err_hold", init_err, !exp_done);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nw, cyc;
    bit md;
    set_tbl(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tr_start", tr_start, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_subaddr", subaddr, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_done", init_done, 0);
    chk("rst_err", init_err, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_addr", addr, 8'h42);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic two writes then end marker
    run(10, 1'b0, 1'b1, 2);

    // delay entry ahead of a write
    set_tbl(16'hFF03, 16'h3A04, 16'hFFFF, 16'h0000);
    run(42, 1'b0, 1'b1, 1);

    // master never answers: timeout
    set_tbl(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    master_en = 1'b0;
    exp_ts_len = TMO;
    run(10, 1'b0, 1'b0, 0);
    master_en = 1'b1;
    exp_ts_len = 2;

    // no end marker: table overrun after every slot is written
    set_tbl(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    run(10, 1'b0, 1'b0, 4);

    // reset in the middle of a transfer, then replay
    set_tbl(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    model(lat, nw, md);
    pulse_start();
    cyc = 0;
    while (!busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_busy_seen", busy, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_tr_start", tr_start, 0);
    chk("midrst_wr_count", wr_count, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_done", init_done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run(10, 1'b0, 1'b1, 2);

    // stray starts during PWR and XFER, then a clean rerun after DONE
    run(10, 1'b1, 1'b1, 2);
    run(10, 1'b0, 1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
